// File: rtl/multicore_mem_ctrl.sv
// Shared DRAM controller: round-robin core arbitration plus an external IRAM/DRAM loader port.
// Define MEMCTRL_STATS_EN to add the stall_cnt/stall_clr core-stall counter.
module multicore_mem_ctrl #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int RD_LAT  = 1
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic [1:0]                  ext_mode,
    input  logic [ADDR_W-1:0]           ext_addr,
    input  logic [DATA_W-1:0]           ext_data,
    input  logic                        ext_valid,
    output logic                        ext_ready,
    output logic [DATA_W-1:0]           ext_rdata,
    output logic                        ext_rvalid,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [N_CORES-1:0]          core_rvalid,
    output logic [ADDR_W-1:0]           iram_addr,
    output logic                        iram_we,
    output logic [DATA_W-1:0]           iram_wdata,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic                        dram_we,
    output logic                        dram_re,
    output logic [DATA_W-1:0]           dram_wdata,
    input  logic [DATA_W-1:0]           dram_rdata,
`ifdef MEMCTRL_STATS_EN
    input  logic                        stall_clr,
    output logic [15:0]                 stall_cnt,
`endif
    output logic                        busy
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

    typedef enum logic [2:0] {
        IDLE, CORE_WR, CORE_RD, RD_WAIT, EXT_ACC, EXT_RD_WAIT
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    winner;
    logic                found;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic [1:0]          acc_mode;
    logic [1:0]          wait_cnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_we;

    // Core handshake: a core holds core_req and operands until it sees its one-cycle
    // core_gnt; a request still high after the grant is arbitrated as a new one.
    always_comb begin : rr_search
        int j;
        j      = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_CORES) j = j - N_CORES;
            if (!found && core_req[IDX_W'(j)]) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr = core_addr[i*ADDR_W +: ADDR_W];
                sel_data = core_wdata[i*DATA_W +: DATA_W];
                sel_we   = core_we[i];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            acc_addr    <= '0;
            acc_data    <= '0;
            acc_mode    <= 2'b00;
            wait_cnt    <= 2'd0;
            ext_ready   <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_gnt    <= '0;
            core_rvalid <= '0;
            iram_addr   <= '0;
            iram_we     <= 1'b0;
            iram_wdata  <= '0;
            dram_addr   <= '0;
            dram_we     <= 1'b0;
            dram_re     <= 1'b0;
            dram_wdata  <= '0;
        end else begin
            ext_ready   <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_gnt    <= '0;
            core_rvalid <= '0;
            iram_we     <= 1'b0;
            dram_we     <= 1'b0;
            dram_re     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_mode != 2'b00) begin
                        if (ext_valid) begin
                            ext_ready <= 1'b1;
                            acc_addr  <= ext_addr;
                            acc_data  <= ext_data;
                            acc_mode  <= ext_mode;
                            state     <= EXT_ACC;
                        end
                    end else if (found) begin
                        core_gnt <= ONE_HOT0 << winner;
                        owner    <= winner;
                        acc_addr <= sel_addr;
                        acc_data <= sel_data;
                        rr_ptr   <= (winner == IDX_W'(N_CORES - 1)) ? '0 : winner + IDX_W'(1);
                        state    <= sel_we ? CORE_WR : CORE_RD;
                    end
                end
                CORE_WR: begin
                    dram_we    <= 1'b1;
                    dram_addr  <= acc_addr;
                    dram_wdata <= acc_data;
                    state      <= IDLE;
                end
                CORE_RD: begin
                    dram_re   <= 1'b1;
                    dram_addr <= acc_addr;
                    wait_cnt  <= 2'(RD_LAT - 1);
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        core_rvalid <= ONE_HOT0 << owner;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                EXT_ACC: begin
                    case (acc_mode)
                        2'b01: begin
                            iram_we    <= 1'b1;
                            iram_addr  <= acc_addr;
                            iram_wdata <= acc_data;
                            state      <= IDLE;
                        end
                        2'b10: begin
                            dram_we    <= 1'b1;
                            dram_addr  <= acc_addr;
                            dram_wdata <= acc_data;
                            state      <= IDLE;
                        end
                        default: begin
                            dram_re   <= 1'b1;
                            dram_addr <= acc_addr;
                            wait_cnt  <= 2'(RD_LAT - 1);
                            state     <= EXT_RD_WAIT;
                        end
                    endcase
                end
                EXT_RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        ext_rvalid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded from the RAM only while the matching valid strobe is high.
    assign core_rdata = (|core_rvalid) ? dram_rdata : '0;
    assign ext_rdata  = ext_rvalid ? dram_rdata : '0;
    assign busy       = (state != IDLE);

`ifdef MEMCTRL_STATS_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (stall_clr) begin
            stall_cnt <= 16'd0;
        end else if ((|core_req) && !(|core_gnt) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicore_mem_ctrl.sv
// Self-checking bench for multicore_mem_ctrl: loader-port vector table, directed
// arbitration/reset sequences and randomized core traffic against a reference model.
module tb_multicore_mem_ctrl;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int RD_LAT = 1;

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rdata;
  } ext_vec_t;

  logic clock, rst_n;
  logic [1:0] ext_mode;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data;
  logic ext_valid, ext_ready, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [N-1:0] core_req, core_we, core_gnt, core_rvalid;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic [AW-1:0] iram_addr, dram_addr;
  logic iram_we, dram_we, dram_re, busy;
  logic [DW-1:0] iram_wdata, dram_wdata, dram_rdata;
`ifdef MEMCTRL_STATS_EN
  logic stall_clr;
  logic [15:0] stall_cnt;
`endif

  logic [DW-1:0] dram_mem [512];
  logic [DW-1:0] rd_s1, rd_s2;
  logic [DW-1:0] model_mem [512];
  logic [DW-1:0] exp_q [$];
  int n_vec, n_miss, model_ptr;
  ext_vec_t ext_tab [7];

  multicore_mem_ctrl #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .rst_n(rst_n),
    .ext_mode(ext_mode), .ext_addr(ext_addr), .ext_data(ext_data), .ext_valid(ext_valid),
    .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .iram_addr(iram_addr), .iram_we(iram_we), .iram_wdata(iram_wdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_re(dram_re), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
`ifdef MEMCTRL_STATS_EN
    .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  // clock / reset and the synchronous DRAM the controller drives
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dram_we) dram_mem[dram_addr] <= dram_wdata;
    if (dram_re) rd_s1 <= dram_mem[dram_addr];
    rd_s2 <= rd_s1;
  end
  assign dram_rdata = (RD_LAT == 2) ? rd_s2 : rd_s1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // reference arbitration: first requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (mask[j]) return j;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_ext_core"}, {ext_ready, ext_rvalid, ext_rdata, core_gnt, core_rdata, core_rvalid, busy}, 64'd0);
    check({name, "_mem"}, {iram_addr, iram_we, iram_wdata, dram_addr, dram_we, dram_re}, 64'd0);
    check({name, "_dwdata"}, dram_wdata, 64'd0);
  endtask

  task automatic set_core(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_we[p] = we;
    core_addr[p*AW +: AW] = a;
    core_wdata[p*DW +: DW] = d;
    core_req[p] = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] mask, output int p);
    int waited;
    p = rr_pick(mask, model_ptr);
    model_ptr = (p + 1) % N;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (core_gnt == '0 && waited < 16);
    check("gnt_vector", core_gnt, onehot(p));
    check("gnt_latency", waited, 1);
  endtask

  task automatic serve(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    if (!we) exp_q.push_back(model_mem[a]);
    @(negedge clock);
    if (we) begin
      check("core_wr", {dram_we, dram_re, dram_addr, dram_wdata}, {1'b1, 1'b0, a, d});
      model_mem[a] = d;
    end else begin
      check("core_rd_strobe", {dram_re, dram_we, dram_addr}, {1'b1, 1'b0, a});
      repeat (RD_LAT) @(negedge clock);
      e = exp_q.pop_front();
      check("core_rd_data", {core_rvalid, core_rdata}, {onehot(p), e});
    end
  endtask

  task automatic ext_access(input ext_vec_t v);
    int waited;
    ext_mode = v.mode; ext_addr = v.addr; ext_data = v.data; ext_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!ext_ready && waited < 16);
    check("ext_ready", ext_ready, 1);
    check("ext_ready_latency", waited, 1);
    ext_valid = 1'b0;
    @(negedge clock);
    case (v.mode)
      2'b01: check("iram_load", {iram_we, dram_we, dram_re, iram_addr, iram_wdata}, {3'b100, v.addr, v.data});
      2'b10: begin
        check("dram_load", {dram_we, iram_we, dram_re, dram_addr, dram_wdata}, {3'b100, v.addr, v.data});
        model_mem[v.addr] = v.data;
      end
      default: begin
        check("ext_rd_strobe", {dram_re, dram_we, dram_addr}, {2'b10, v.addr});
        repeat (RD_LAT) @(negedge clock);
        check("ext_readback", {ext_rvalid, ext_rdata}, {1'b1, v.exp_rdata});
      end
    endcase
  endtask

  initial begin
    int p;
    int rr_order [5];
    logic [AW-1:0] rr_addr [N];
    n_vec = 0; n_miss = 0; model_ptr = 0;
    for (int i = 0; i < 512; i++) begin
      dram_mem[i] = '0;
      model_mem[i] = '0;
    end
    rd_s1 = '0; rd_s2 = '0;
    ext_tab[0] = '{2'b01, 9'h005, 16'hABCD, 16'h0000};
    ext_tab[1] = '{2'b01, 9'h1FF, 16'h5A5A, 16'h0000};
    ext_tab[2] = '{2'b10, 9'h010, 16'h1234, 16'h0000};
    ext_tab[3] = '{2'b10, 9'h1FF, 16'h0F0F, 16'h0000};
    ext_tab[4] = '{2'b11, 9'h010, 16'h0000, 16'h1234};
    ext_tab[5] = '{2'b11, 9'h1FF, 16'h0000, 16'h0F0F};
    ext_tab[6] = '{2'b11, 9'h000, 16'h0000, 16'h0000};
    rr_order = '{0, 1, 2, 3, 0};
    rr_addr = '{9'h010, 9'h1FF, 9'h000, 9'h005};

    rst_n = 1'b0; ext_mode = 2'b00; ext_addr = '0; ext_data = '0; ext_valid = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
`ifdef MEMCTRL_STATS_EN
    stall_clr = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ext_valid in run mode must be ignored
    ext_valid = 1'b1; ext_addr = 9'h033; ext_data = 16'hDEAD;
    repeat (3) begin
      @(negedge clock);
      check("ext_ignored_run_mode", {ext_ready, busy}, 0);
    end
    ext_valid = 1'b0;

    for (int i = 0; i < 7; i++) ext_access(ext_tab[i]);
    ext_mode = 2'b00;

    // continuous requests from all cores: order 0,1,2,3,0
    for (int q = 0; q < N; q++) set_core(q, 1'b0, rr_addr[q], '0);
    for (int k = 0; k < 5; k++) begin
      wait_grant({N{1'b1}}, p);
      check("rr_order", core_gnt, onehot(rr_order[k]));
      if (k == 4) core_req = '0;
      serve(p, 1'b0, rr_addr[p], '0);
    end

    // core 2 write in flight while the loader switches to DRAM load
    set_core(2, 1'b1, 9'h020, 16'h00FF);
    wait_grant(4'b0100, p);
    core_req[2] = 1'b0;
    set_core(1, 1'b0, 9'h030, '0);
    ext_mode = 2'b10; ext_addr = 9'h030; ext_data = 16'hC0DE; ext_valid = 1'b1;
    @(negedge clock);
    check("contention_core_wr", {dram_we, dram_addr, dram_wdata}, {1'b1, 9'h020, 16'h00FF});
    model_mem[9'h020] = 16'h00FF;
    @(negedge clock);
    check("contention_ext_ready", {ext_ready, core_gnt}, {1'b1, 4'b0000});
    ext_valid = 1'b0;
    @(negedge clock);
    check("contention_ext_wr", {dram_we, core_gnt, dram_addr, dram_wdata}, {1'b1, 4'b0000, 9'h030, 16'hC0DE});
    model_mem[9'h030] = 16'hC0DE;
    @(negedge clock);
    check("contention_no_gnt", core_gnt, 0);
    ext_mode = 2'b00;
    wait_grant(4'b0010, p);
    core_req[1] = 1'b0;
    serve(p, 1'b0, 9'h030, '0);

    // asynchronous reset while a read waits for data
    set_core(2, 1'b0, 9'h010, '0);
    wait_grant(4'b0100, p);
    core_req[2] = 1'b0;
    @(negedge clock);
    check("pre_reset_rd_strobe", {dram_re, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    rst_n = 1'b1;
    model_ptr = 0;
    set_core(0, 1'b0, 9'h010, '0);
    set_core(3, 1'b0, 9'h1FF, '0);
    wait_grant(4'b1001, p);
    check("post_reset_core0", core_gnt, 4'b0001);
    core_req[0] = 1'b0;
    serve(p, 1'b0, 9'h010, '0);
    wait_grant(4'b1000, p);
    core_req[3] = 1'b0;
    serve(p, 1'b0, 9'h1FF, '0);

    // randomized traffic against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] mask;
      logic [AW-1:0] ra [N];
      logic [DW-1:0] rd [N];
      logic rw [N];
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int q = 0; q < N; q++) begin
        rw[q] = 1'($urandom_range(0, 1));
        ra[q] = AW'(9'h040 + $urandom_range(0, 7));
        rd[q] = DW'($urandom);
        if (mask[q]) set_core(q, rw[q], ra[q], rd[q]);
      end
      while (mask != '0) begin
        wait_grant(mask, p);
        core_req[p] = 1'b0;
        mask[p] = 1'b0;
        serve(p, rw[p], ra[p], rd[p]);
      end
    end

`ifdef MEMCTRL_STATS_EN
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    check("stall_reset", stall_cnt, 0);
    for (int q = 0; q < 3; q++) set_core(q, 1'b0, 9'h010, '0);
    repeat (12) @(negedge clock);
    core_req = '0;
    check("stall_cnt_12cyc", stall_cnt, 8);
    repeat (4) @(negedge clock);
    stall_clr = 1'b1;
    @(negedge clock);
    stall_clr = 1'b0;
    check("stall_clr", stall_cnt, 0);
`endif

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/multicore_mem_ctrl.md
Name: multicore_mem_ctrl

Overview:
Parametrised shared-memory controller for the N-core processor.
- Arbitrates DRAM access from N_CORES cores with a round-robin valid/grant handshake.
- Multiplexes an external loader port for IRAM load, DRAM load and DRAM readback.
- Sits between the core array and the single-port synchronous iram/dram instances, replacing the per-clock start/start_2/start_3/start_4 muxing with a registered FSM.

Parameters:
N_CORES, 4, number of cores sharing DRAM (2..8)
DATA_W, 16, data word width
ADDR_W, 9, memory address width
RD_LAT, 1, DRAM read latency in cycles (1 or 2)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ext_mode  in  2  00 run, 01 IRAM load, 10 DRAM load, 11 DRAM readback
ext_addr  in  ADDR_W  external address
ext_data  in  DATA_W  external write data
ext_valid  in  1  external access request
ext_ready  out  1  external access accepted this cycle
ext_rdata  out  DATA_W  readback data
ext_rvalid  out  1  readback data valid
core_req  in  N_CORES  per-core access request
core_we  in  N_CORES  per-core write (1) / read (0)
core_addr  in  N_CORES*ADDR_W  packed addresses, core 0 in LSBs
core_wdata  in  N_CORES*DATA_W  packed write data
core_gnt  out  N_CORES  one-hot grant
core_rdata  out  DATA_W  read data, broadcast to all cores
core_rvalid  out  N_CORES  one-hot read-data valid
iram_addr / iram_we / iram_wdata  out  ADDR_W / 1 / DATA_W  IRAM write port
dram_addr / dram_we / dram_re / dram_wdata  out  ADDR_W / 1 / 1 / DATA_W  DRAM port
dram_rdata  in  DATA_W  DRAM read data
busy  out  1  transaction in flight

Behaviour:
- Reset: all outputs 0; FSM in IDLE; round-robin pointer set to core 0.
- FSM states: IDLE, CORE_WR, CORE_RD, RD_WAIT, EXT_ACC, EXT_RD_WAIT. All memory-side outputs are registered.
- IDLE, ext_mode!=00: core requests are ignored.
  - If ext_valid is high, assert ext_ready for one cycle, register the access, and go to EXT_ACC.
- EXT_ACC:
  - Mode 01: drive iram_we=1 for one cycle.
  - Mode 10: drive dram_we=1 for one cycle.
  - Mode 11: drive dram_re=1, then go to EXT_RD_WAIT.
  - Modes 01 and 10 return to IDLE.
- EXT_RD_WAIT: wait RD_LAT cycles, then pulse ext_rvalid for one cycle with ext_rdata = dram_rdata. Return to IDLE.
- IDLE, ext_mode==00, any core_req set:
  - Grant the first requesting core at or after the RR pointer, searching upward with wrap-around from N_CORES-1 to 0.
  - core_gnt is a one-cycle pulse.
  - Latch that core's addr, we and wdata.
  - Advance the pointer to winner+1 mod N_CORES.
- CORE_WR: dram_we=1 for one cycle, then IDLE.
- CORE_RD: dram_re=1, then RD_WAIT.
- RD_WAIT: after RD_LAT cycles, core_rdata = dram_rdata and core_rvalid[winner] pulses for one cycle. Then IDLE.
- Throughput: 2 cycles per write, 2+RD_LAT cycles per read; a new grant is possible on the cycle IDLE is re-entered.
- Core handshake: a core holds core_req and its operands until it sees core_gnt. The request is deasserted or renewed the cycle after the grant. Requests held past the grant are treated as new requests.
- ext_mode changing mid-transaction: the in-flight transaction completes; the new mode takes effect from IDLE. ext_valid with ext_mode==00 is ignored.
- Simultaneous ext and core requests: ext_mode!=00 always wins.
- Reset mid-operation: the FSM aborts immediately and all strobes drop to 0. No partial write is re-issued.
- busy = (state != IDLE).
- iram_wdata/dram_wdata hold their last value when not strobed.

Optional Feature:
MEMCTRL_STATS_EN
- Defined: adds output stall_cnt [15:0] and input stall_clr.
- stall_cnt increments, saturating at 16'hFFFF, on every cycle where core_req has at least one bit set and no core_gnt is issued.
- stall_clr synchronously zeroes the counter; a clear takes priority over an increment in the same cycle.
- Reset value is 0.
- Undefined: no stall_cnt/stall_clr ports and no counter logic.

Test Plan:
- IRAM load: ext_mode=01, ext_valid at addr 9'h005, data 16'hABCD -> ext_ready pulse; next cycle iram_we=1, iram_addr=5, iram_wdata=ABCD.
- DRAM readback: preload 9'h010=16'h1234 via mode 10, then mode 11 read -> ext_rvalid pulses after 2+RD_LAT cycles with ext_rdata=1234.
- Round-robin: all 4 cores request reads continuously -> grant order 0,1,2,3,0; core_rvalid one-hot matches each grant.
- Contention: core 2 writes 16'h00FF to 9'h020 while ext_mode switches to 10 mid-write -> core write completes, then ext access is served; no core_gnt while ext_mode!=00.
- Async reset: assert rst_n=0 in RD_WAIT -> all outputs 0 immediately, FSM in IDLE, next grant goes to core 0.
- Stats (MEMCTRL_STATS_EN): 3 cores requesting for 12 cycles at RD_LAT=1 -> stall_cnt=8; stall_clr -> 0.
